fifo_write_arbiter: RTL

Round-robin arbiter that shares the single write port of the Fifo among NUM_REQ requesters in the write clock domain. Each requester uses a valid/ready handshake. The arbiter grants one requester at a time for a burst of up to MAX_BURST beats, drives Fifo write/writeData, and honours Fifo full as backpressure. It sits directly in front of the Fifo write side and replaces any ad-hoc write muxing.

---
 rtl/fifo_write_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the Fifo write port among NUM_REQ requesters.
// Grants last up to MAX_BURST beats; Fifo full stalls the current grant.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         writeClk,
  input  logic                         writeRst,
  input  logic [NUM_REQ-1:0]           reqValid,
  input  logic [NUM_REQ*WIDTH-1:0]     reqData,
  output logic [NUM_REQ-1:0]           reqReady,
  input  logic                         full,
  output logic                         write,
  output logic [WIDTH-1:0]             writeData,
  output logic [$clog2(NUM_REQ)-1:0]   grantId,
  output logic                         busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic [CW-1:0]  burstCnt;

  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   nextPtr;
  logic [WIDTH-1:0] ownerData;
  logic             anyValid;
  logic             ownerValid;
  logic             granted;
  logic             beat;
  logic             lastBeat;
  logic             rel;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    pick  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && reqValid[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  assign anyValid   = |reqValid;
  assign ownerValid = reqValid[owner];
  assign ownerData  = reqData[owner*WIDTH +: WIDTH];

  assign nextPtr = (owner == IDW'(NUM_REQ - 1)) ?
                   '0 : owner + 1'b1;

  // Outputs are forced quiet during reset, whatever state holds.
  assign granted  = (state == GRANT) && !writeRst;
  assign beat     = granted && ownerValid && !full;
  assign lastBeat = (burstCnt == CW'(MAX_BURST - 1));
  assign rel      = !full && ((beat && lastBeat) ||
                              !ownerValid);

  assign write     = beat;
  assign writeData = beat ? ownerData : '0;
  assign busy      = granted;
  assign grantId   = granted ? owner : '0;

  always_comb begin
    reqReady = '0;
    if (granted && !full) reqReady[owner] = 1'b1;
  end

  always_ff @(posedge writeClk) begin
    if (writeRst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      burstCnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (anyValid) begin
            owner    <= pick;
            burstCnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr      <= nextPtr;
            burstCnt <= '0;
            state    <= IDLE;
          end else if (beat) begin
            burstCnt <= burstCnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
